// File: rtl/cla_seq_adder_ctrl.sv
// Wide adder controller: reuses one SLICE_W-bit carry-lookahead slice over WORDS cycles.
// Optional SEQ_ADDER_SUBTRACT_EN adds a 'sub' input that turns the operation into a-b.
module cla_seq_adder_ctrl #(
  parameter int SLICE_W = 16,
  parameter int WORDS   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [SLICE_W*WORDS-1:0]   a,
  input  logic [SLICE_W*WORDS-1:0]   b,
  input  logic                       cin,
`ifdef SEQ_ADDER_SUBTRACT_EN
  input  logic                       sub,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SLICE_W*WORDS-1:0]   sum,
  output logic                       cout,
  output logic                       ovf,
  output logic                       busy
);

  localparam int N      = SLICE_W * WORDS;
  localparam int GROUPS = SLICE_W / 4;
  localparam int IDX_W  = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, next_state_s;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic [N-1:0]       a_r, b_r, sum_r;
  logic               cout_r, ovf_r, out_valid_r, busy_r, start_ready_r;
  logic [N-1:0]       b_eff_s;
  logic               cin_eff_s;
  logic [SLICE_W-1:0] a_word_s, b_word_s;
  logic [SLICE_W:0]   slice_res_s;
  logic               last_s;

  // Lookahead slice: 4-bit groups with full in-group lookahead, group P/G chained to the slice carry.
  function automatic logic [SLICE_W:0] cla_slice(input logic [SLICE_W-1:0] x,
                                                 input logic [SLICE_W-1:0] y,
                                                 input logic c_in);
    logic [SLICE_W-1:0] p, g, s;
    logic [GROUPS:0]    gc;
    logic [3:0]         gp, gg, c;
    logic               grp_g, grp_p;
    p     = x ^ y;
    g     = x & y;
    s     = {SLICE_W{1'b0}};
    gc    = {(GROUPS+1){1'b0}};
    gc[0] = c_in;
    for (int k = 0; k < GROUPS; k++) begin
      gp    = p[4*k +: 4];
      gg    = g[4*k +: 4];
      c[0]  = gc[k];
      c[1]  = gg[0] | (gp[0] & c[0]);
      c[2]  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
      c[3]  = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c[0]);
      grp_g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
      grp_p = &gp;
      gc[k+1]    = grp_g | (grp_p & gc[k]);
      s[4*k +: 4] = gp ^ c;
    end
    return {gc[GROUPS], s};
  endfunction

`ifdef SEQ_ADDER_SUBTRACT_EN
  assign b_eff_s   = sub ? ~b : b;
  assign cin_eff_s = sub ? 1'b1 : cin;
`else
  assign b_eff_s   = b;
  assign cin_eff_s = cin;
`endif

  assign a_word_s    = a_r[int'(idx_r)*SLICE_W +: SLICE_W];
  assign b_word_s    = b_r[int'(idx_r)*SLICE_W +: SLICE_W];
  assign slice_res_s = cla_slice(a_word_s, b_word_s, carry_r);
  assign last_s      = (idx_r == IDX_W'(WORDS-1));

  // Next-state decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_valid) next_state_s = RUN;
        else             next_state_s = IDLE;
      end
      RUN: begin
        if (last_s) next_state_s = DONE;
        else        next_state_s = RUN;
      end
      DONE: begin
        if (out_ready) next_state_s = IDLE;
        else           next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, datapath registers and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      idx_r         <= {IDX_W{1'b0}};
      carry_r       <= 1'b0;
      a_r           <= {N{1'b0}};
      b_r           <= {N{1'b0}};
      sum_r         <= {N{1'b0}};
      cout_r        <= 1'b0;
      ovf_r         <= 1'b0;
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      start_ready_r <= 1'b1;
    end else begin
      state_r       <= next_state_s;
      start_ready_r <= (next_state_s == IDLE);
      busy_r        <= (next_state_s != IDLE);
      out_valid_r   <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            a_r     <= a;
            b_r     <= b_eff_s;
            carry_r <= cin_eff_s;
            idx_r   <= {IDX_W{1'b0}};
            sum_r   <= {N{1'b0}};
          end
        end
        RUN: begin
          sum_r[int'(idx_r)*SLICE_W +: SLICE_W] <= slice_res_s[SLICE_W-1:0];
          carry_r <= slice_res_s[SLICE_W];
          if (last_s) begin
            // ovf uses the latched (possibly inverted) b MSB.
            cout_r <= slice_res_s[SLICE_W];
            ovf_r  <= (a_r[N-1] ~^ b_r[N-1]) & (a_r[N-1] ^ slice_res_s[SLICE_W-1]);
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign start_ready = start_ready_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign sum         = sum_r;
  assign cout        = cout_r;
  assign ovf         = ovf_r;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed self-checking bench for cla_seq_adder_ctrl (default SLICE_W=16, WORDS=4).
module tb_cla_seq_adder_ctrl;

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [63:0] a, b;
  logic        cin;
`ifdef SEQ_ADDER_SUBTRACT_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int checks;
  int failures;

  cla_seq_adder_ctrl #(.SLICE_W(16), .WORDS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
`ifdef SEQ_ADDER_SUBTRACT_EN
    .sub         (sub),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one operation and wait (bounded) for out_valid; leaves the result in DONE.
  task automatic start_op(input logic [63:0] av, input logic [63:0] bv, input logic ci, input logic sb);
    int cnt;
    @(negedge clk);
    a = av; b = bv; cin = ci; start_valid = 1'b1;
`ifdef SEQ_ADDER_SUBTRACT_EN
    sub = sb;
`else
    if (sb) $display("note: sub ignored in add-only build");
`endif
    check_value("start_ready_idle", {63'd0, start_ready}, 64'd1);
    @(posedge clk);
    #1 start_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1 cnt++;
    end
    check_value("latency", 64'(cnt), 64'd4);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_value("out_valid_drop", {63'd0, out_valid}, 64'd0);
    check_value("start_ready_back", {63'd0, start_ready}, 64'd1);
  endtask

  task automatic check_result(input string tag, input logic [63:0] es, input logic ec, input logic eo);
    check_value({tag, "_sum"}, sum, es);
    check_value({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
    check_value({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start_valid = 1'b0; out_ready = 1'b0;
    a = 64'd0; b = 64'd0; cin = 1'b0;
`ifdef SEQ_ADDER_SUBTRACT_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_value("rst_sum", sum, 64'd0);
    check_value("rst_flags", {59'd0, out_valid, busy, start_ready, cout, ovf}, 64'b00100);

    // Carry from slice 0 into slice 1
    start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    check_result("t1", 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    check_value("t1_busy", {63'd0, busy}, 64'd1);
    release_result();

    // Full ripple across all slices
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    check_result("t2", 64'h0, 1'b1, 1'b0);
    release_result();

    // Signed overflow
    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    check_result("t3", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    release_result();
    check_value("t3_retain", sum, 64'h8000_0000_0000_0000);

    // Reset after two slices have been written
    @(negedge clk);
    a = 64'h1111_1111_1111_1111; b = 64'h1111_1111_1111_1111; cin = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_value("t5_partial", sum, 64'h0000_0000_2222_2222);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_value("t5_rst_sum", sum, 64'd0);
    check_value("t5_rst_flags", {59'd0, out_valid, busy, start_ready, cout, ovf}, 64'b00100);
    start_op(64'd3, 64'd4, 1'b0, 1'b0);
    check_result("t5", 64'd7, 1'b0, 1'b0);
    release_result();

    // Backpressure with a competing request and changing operands
    start_op(64'h1234, 64'h1111, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_valid = 1'b1; a = 64'hDEAD_0000 + 64'(i); b = 64'hFFFF_FFFF; cin = 1'b1;
      check_value("t4_sum_hold", sum, 64'h2345);
      check_value("t4_ctrl", {61'd0, out_valid, busy, start_ready}, 64'b110);
    end
    @(negedge clk);
    start_valid = 1'b0;
    check_result("t4", 64'h2345, 1'b0, 1'b0);
    release_result();
    check_value("t4_idle_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check_value("t4_no_new_op", {62'd0, busy, out_valid}, 64'd0);

`ifdef SEQ_ADDER_SUBTRACT_EN
    start_op(64'd5, 64'd7, 1'b0, 1'b1);
    check_result("t6a", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    release_result();
    start_op(64'd7, 64'd5, 1'b0, 1'b1);
    check_result("t6b", 64'd2, 1'b1, 1'b0);
    release_result();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
